fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch front end. Consumes the PC register's `pc_out`, computes `pc_next` back into it, issues instruction-memory requests and buffers returned instructions for decode.
- Owns the hold / advance / redirect decision for the PC, so the PC register itself stays a plain loadable flop.
- Sits between the PC register and the ID stage.

Parameters:
- `XLEN`, 32, address and instruction width.
- `RESET_PC`, 32'h0000_0000, value driven on `pc_next` during reset; must equal the PC register's reset value.
- `FIFO_DEPTH`, 2, instruction buffer entries; power of two, at least 2.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `pc_in`  in  XLEN  current PC, from the PC register's `pc_out`
- `pc_next`  out  XLEN  next PC, to the PC register's `pc_next`
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  XLEN  fetch address, always equal to `pc_in`
- `imem_req_ready`  in  1  memory accepts the request
- `imem_rsp_valid`  in  1  response valid; in order, at least 1 cycle after accept
- `imem_rsp_data`  in  XLEN  fetched instruction
- `redirect_valid`  in  1  branch/jump/exception redirect
- `redirect_pc`  in  XLEN  redirect target
- `id_valid`  out  1  instruction available to decode
- `id_instr`  out  XLEN  instruction at FIFO head
- `id_pc`  out  XLEN  PC of that instruction
- `id_ready`  in  1  decode consumes the head this cycle

Behaviour:
- Reset (synchronous, active-high):
  - `state` = IDLE, FIFO empty, `imem_req_valid` = 0, `id_valid` = 0.
  - `pc_next` = `RESET_PC` while `reset` is high.
  - Reset wins over every other input.
- At most one request outstanding. FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response will be kept.
  - WAIT_DISCARD: request outstanding, response will be dropped.
- `imem_req_valid` = (state == IDLE) && (`count` + 1 <= `FIFO_DEPTH`) && !`redirect_valid`.
- Accept: `imem_req_valid` && `imem_req_ready`.
  - IDLE -> WAIT.
  - Capture `pc_in` as `req_pc`.
- `pc_next` priority:
  1. `reset` -> `RESET_PC`.
  2. `redirect_valid` -> {`redirect_pc`[XLEN-1:2], 2'b00}; low bits are forced to zero.
  3. accept -> `pc_in` + 4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
  4. otherwise -> `pc_in` (hold).
- Response in WAIT:
  - Push {`req_pc`, `imem_rsp_data`} into the FIFO; WAIT -> IDLE.
  - The entry is visible on `id_*` the next cycle (1-cycle rsp-to-id latency).
- Response in WAIT_DISCARD: data dropped; WAIT_DISCARD -> IDLE.
- Response in IDLE: ignored (protocol violation; an assertion flags it in simulation).
- Redirect:
  - FIFO flushed (`count` = 0) and `id_valid` = 0 on the next cycle.
  - WAIT -> WAIT_DISCARD. WAIT_DISCARD stays. IDLE stays, with no request that cycle.
  - A response arriving in the same cycle as the redirect while in WAIT is dropped; next state is IDLE.
  - Redirect and `id_ready` in the same cycle: the flush wins; the pop is a no-op.
- FIFO:
  - Circular buffer with `rd_ptr`, `wr_ptr` and `count`.
  - Push and pop in the same cycle leave `count` unchanged.
  - The request gate means the FIFO never overflows.
  - `id_valid` = (`count` != 0). `id_instr` and `id_pc` come from the head entry and are held stable while `id_valid` && !`id_ready`.
- Full FIFO with no pop: no requests issue and `pc_next` holds, so the PC stalls naturally.

Decomposition:
- Shared package `core_pkg`:
  - `XLEN`, `RESET_PC`.
  - `PC_STEP` = 4.
  - Fetch FSM enum `fetch_state_t` {IDLE, WAIT, WAIT_DISCARD}.
- One sub-module: `fetch_fifo` (parameterised `DEPTH`, `WIDTH` = 2*XLEN). Ports: push, pop, flush, din, dout, count, empty, full.
- FSM and next-PC logic live in `fetch_unit`.

Test Plan:
- Streaming fetch:
  - Setup: `pc` tied to `pc_next` via a PC register, memory always ready, 1-cycle response, `id_ready` = 1.
  - Expect `id_pc` sequence 0, 4, 8, 12, one instruction every 2 cycles, `id_instr` matching memory contents.
- Backpressure:
  - Setup: `id_ready` = 0.
  - Expect exactly 2 instructions buffered (PCs 0, 4), then `imem_req_valid` = 0 and `pc_next` holding at 8.
  - Raise `id_ready`: PC 0 pops first, then fetching resumes at 8.
- Redirect during WAIT:
  - Stimulus: `redirect_pc` = 32'h100 one cycle after the request for 8 is accepted.
  - Expect the response for 8 dropped, next `id_pc` = 32'h100, no stale `id_valid`.
- Redirect coincident with response, plus misalignment:
  - Stimulus: `redirect_pc` = 32'h203 in the same cycle as `imem_rsp_valid`.
  - Expect the response dropped and `pc_next` = 32'h200.
- Wrap-around: start at `pc` = 32'hFFFF_FFFC; expect `id_pc` 32'hFFFF_FFFC followed by 0.
- Reset mid-operation:
  - Stimulus: assert `reset` in WAIT with the FIFO holding 1 entry.
  - Expect next cycle: `id_valid` = 0, `imem_req_valid` = 0, `pc_next` = `RESET_PC`.
  - Expect the late `imem_rsp_valid` after reset to be ignored.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared fetch widths, reset PC, PC step and fetch FSM states
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular {pc,instr} buffer; push/pop/flush in, head dout, count/empty/full out
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic do_push, do_pop;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_q <= '0;
      wr_q <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch front end; pc_in -> pc_next, imem req/rsp, buffered id_valid/id_instr/id_pc, redirect flush
module fetch_unit #(
  parameter int              XLEN       = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = core_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);
  import core_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state_q;
  logic [XLEN-1:0] req_pc_q;
  logic rst_d_q;
  logic accept, push, empty, full;
  logic [CW-1:0] count;
  logic [2*XLEN-1:0] head;
  assign imem_req_valid = !reset && state_q == IDLE && int'(count) < FIFO_DEPTH && !redirect_valid;
  assign imem_req_addr = pc_in;
  assign accept = imem_req_valid && imem_req_ready;
  // a response racing a redirect belongs to the old path and is dropped
  assign push = state_q == WAIT && imem_rsp_valid && !redirect_valid;
  assign pc_next = reset ? RESET_PC : redirect_valid ? (redirect_pc & ~XLEN'(3)) : accept ? pc_in + XLEN'(PC_STEP) : pc_in;
  assign id_valid = !empty;
  assign id_pc = head[2*XLEN-1:XLEN];
  assign id_instr = head[XLEN-1:0];
  always_ff @(posedge clk) begin
    rst_d_q <= reset;
    if (reset) begin
      state_q <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q <= accept ? WAIT
               : (state_q == WAIT && redirect_valid && !imem_rsp_valid) ? WAIT_DISCARD
               : (state_q != IDLE && imem_rsp_valid) ? IDLE : state_q;
      if (accept) req_pc_q <= pc_in;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*XLEN)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(id_ready), .flush(redirect_valid),
    .din({req_pc_q, imem_rsp_data}), .dout(head), .count(count), .empty(empty), .full(full)
  );
  // a request in flight across reset may still answer in the first cycle after it
  a_no_idle_rsp: assert property (@(posedge clk) disable iff (reset || rst_d_q) !(imem_rsp_valid && state_q == IDLE));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule
